// File: rtl/intc_prio.sv
// Prioritised interrupt controller: latches, masks and prioritises up to 8 sources
// into one registered CPU interrupt, with a 4-byte PEND/MASK/EDGE/VECTOR window.
module intc_prio #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  input  logic [N_SRC-1:0] src,
  output logic             intr
);

  // Bits at or above N_SRC are held at zero in every register.
  localparam logic [8:0] TOP_BIT = 9'd1 << N_SRC;
  localparam logic [7:0] IMPL    = 8'(TOP_BIT - 9'd1);

  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] src_q,  src_d;
  logic [7:0] snap_q, snap_d;
  logic       gie_q,  gie_d;
  logic       ack_q,  ack_d;
  logic       intr_q, intr_d;

  logic [7:0] src_ext;
  logic [7:0] act;
  logic       valid;
  logic [2:0] idx;
  logic [7:0] live_vec;
  logic       wr_stb;
  logic       rd_vec;
  logic       first;
  logic [7:0] clr;
  logic [7:0] ack;

  always_comb begin
    src_ext = '0;
    for (int i = 0; i < N_SRC; i++) src_ext[i] = src[i];
  end

  // Lowest-numbered enabled pending source wins.
  always_comb begin
    act   = pend_q & mask_q;
    valid = |act;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (act[i]) idx = 3'(i);
    end
    live_vec = {valid, gie_q, 3'b000, idx};
  end

  // A VECTOR read acknowledges once, on the first cycle of each contiguous cs access.
  always_comb begin
    wr_stb = cs & ~rw;
    rd_vec = cs & rw & (AD == 2'd3);
    first  = rd_vec & ~ack_q;
    clr    = (wr_stb && AD == 2'd0) ? (DI & edge_q) : 8'h00;
    ack    = (first && valid) ? (8'h01 << idx) : 8'h00;
  end

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    gie_d  = gie_q;
    snap_d = snap_q;
    src_d  = src_ext;
    ack_d  = rd_vec;
    intr_d = gie_q & valid;
    pend_d = '0;
    for (int i = 0; i < 8; i++) begin
      // Set has priority over W1C and acknowledge so no edge is lost.
      pend_d[i] = edge_q[i] ? ((pend_q[i] & ~clr[i] & ~ack[i]) | (src_ext[i] & ~src_q[i]))
                            : src_ext[i];
    end
    pend_d = pend_d & IMPL;
    if (wr_stb) begin
      case (AD)
        2'd1:    mask_d = DI & IMPL;
        2'd2:    edge_d = DI & IMPL;
        2'd3:    gie_d  = DI[6];
        default: ;
      endcase
    end
    if (first) snap_d = live_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
      mask_q <= '0;
      edge_q <= '0;
      src_q  <= '0;
      snap_q <= '0;
      gie_q  <= 1'b0;
      ack_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      src_q  <= src_d;
      snap_q <= snap_d;
      gie_q  <= gie_d;
      ack_q  <= ack_d;
      intr_q <= intr_d;
    end
  end

  // Later cycles of a VECTOR read return the snapshot so the value stays stable.
  always_comb begin
    case (AD)
      2'd0:    DO = pend_q;
      2'd1:    DO = mask_q;
      2'd2:    DO = edge_q;
      default: DO = first ? live_vec : snap_q;
    endcase
  end

  assign intr = intr_q;

endmodule

// File: tb/tb_intc_prio.sv
// Directed bench for intc_prio: an 8-source instance and a 3-source instance
// sharing the bus, selected by sel3.
module tb_intc_prio;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ad;
  logic [7:0] di;
  logic       rw;
  logic       cs_bus;
  logic       sel3;
  logic [7:0] src;
  logic [7:0] do_8, do_3, do_sel;
  logic       intr_8, intr_3;
  logic       cs_8, cs_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cs_8   = cs_bus & ~sel3;
  assign cs_3   = cs_bus & sel3;
  assign do_sel = sel3 ? do_3 : do_8;

  intc_prio #(.N_SRC(8)) u8 (
    .clk(clk), .rst(rst), .AD(ad), .DI(di), .DO(do_8),
    .rw(rw), .cs(cs_8), .src(src), .intr(intr_8)
  );

  intc_prio #(.N_SRC(3)) u3 (
    .clk(clk), .rst(rst), .AD(ad), .DI(di), .DO(do_3),
    .rw(rw), .cs(cs_3), .src(src[2:0]), .intr(intr_3)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs_bus = 1'b1; rw = 1'b0; ad = a; di = d;
    tick();
    cs_bus = 1'b0; rw = 1'b1;
  endtask

  // Multi-cycle read; every cycle of the access must return exp, then one idle cycle.
  task automatic rd(input string tag, input logic [1:0] a, input int n, input logic [7:0] exp);
    cs_bus = 1'b1; rw = 1'b1; ad = a;
    for (int k = 0; k < n; k++) begin
      #1;
      check(tag, do_sel, exp);
      tick();
    end
    cs_bus = 1'b0;
    tick();
  endtask

  // Combinational look without a clock edge, so no acknowledge is taken.
  task automatic peek(input string tag, input logic [1:0] a, input logic [7:0] exp);
    cs_bus = 1'b1; rw = 1'b1; ad = a;
    #1;
    check(tag, do_sel, exp);
    cs_bus = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ad = 2'd0; di = 8'h00; rw = 1'b1; cs_bus = 1'b0; sel3 = 1'b0;
    src = 8'hFF;

    // Reset with all sources high
    tick(); tick();
    peek("rst_pend", 2'd0, 8'h00);
    peek("rst_mask", 2'd1, 8'h00);
    peek("rst_edge", 2'd2, 8'h00);
    peek("rst_vec",  2'd3, 8'h00);
    check("rst_intr8", {7'b0, intr_8}, 8'h00);
    check("rst_intr3", {7'b0, intr_3}, 8'h00);
    rst = 1'b1; src = 8'h00;
    tick(); tick();
    check("post_rst_intr", {7'b0, intr_8}, 8'h00);

    // Edge latch and priority
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'h24);
    wr(2'd3, 8'h40);
    src = 8'h24;
    tick();
    src = 8'h00;
    check("edge_intr_lat1", {7'b0, intr_8}, 8'h00);
    tick();
    check("edge_intr_lat2", {7'b0, intr_8}, 8'h01);
    rd("vec_c2", 2'd3, 3, 8'hC2);
    rd("pend_after_ack2", 2'd0, 1, 8'h20);
    cs_bus = 1'b1; rw = 1'b1; ad = 2'd3;
    #1;
    check("vec_c5", do_sel, 8'hC5);
    tick();
    cs_bus = 1'b0;
    check("intr_hold", {7'b0, intr_8}, 8'h01);
    tick();
    check("intr_fall", {7'b0, intr_8}, 8'h00);
    rd("pend_empty", 2'd0, 1, 8'h00);

    // Level mode: ack does not clear a level source
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h01);
    src = 8'h01;
    tick();
    rd("lvl_vec_a", 2'd3, 2, 8'hC0);
    rd("lvl_vec_b", 2'd3, 1, 8'hC0);
    check("lvl_intr", {7'b0, intr_8}, 8'h01);
    src = 8'h00;
    tick();
    peek("lvl_pend_drop", 2'd0, 8'h00);
    check("lvl_intr_still", {7'b0, intr_8}, 8'h01);
    tick();
    check("lvl_intr_drop", {7'b0, intr_8}, 8'h00);

    // Set beats W1C clear
    wr(2'd2, 8'h08);
    src = 8'h08; tick();
    src = 8'h00; tick();
    peek("sbc_pend_set", 2'd0, 8'h08);
    cs_bus = 1'b1; rw = 1'b0; ad = 2'd0; di = 8'h08; src = 8'h08;
    tick();
    cs_bus = 1'b0; rw = 1'b1; src = 8'h00;
    peek("sbc_set_wins", 2'd0, 8'h08);
    tick();
    wr(2'd0, 8'h08);
    peek("sbc_w1c", 2'd0, 8'h00);

    // Masking and GIE
    wr(2'd2, 8'h80);
    wr(2'd1, 8'h00);
    src = 8'h80; tick();
    src = 8'h00; tick();
    check("msk_intr_off", {7'b0, intr_8}, 8'h00);
    peek("msk_pend", 2'd0, 8'h80);
    peek("msk_vec", 2'd3, 8'h40);
    wr(2'd1, 8'h80);
    check("unmask_intr_lat", {7'b0, intr_8}, 8'h00);
    tick();
    check("unmask_intr", {7'b0, intr_8}, 8'h01);
    wr(2'd3, 8'h00);
    tick();
    check("gie_off_intr", {7'b0, intr_8}, 8'h00);
    peek("gie_off_vec", 2'd3, 8'h87);

    // Three-source instance
    sel3 = 1'b1;
    wr(2'd1, 8'hFF);
    peek("n3_mask", 2'd1, 8'h07);
    wr(2'd2, 8'hFF);
    peek("n3_edge", 2'd2, 8'h07);
    wr(2'd3, 8'h40);
    src = 8'h06; tick();
    src = 8'h00; tick();
    check("n3_intr", {7'b0, intr_3}, 8'h01);
    rd("n3_vec_c1", 2'd3, 2, 8'hC1);
    rd("n3_vec_c2", 2'd3, 1, 8'hC2);
    peek("n3_pend_empty", 2'd0, 8'h00);
    tick();
    check("n3_intr_off", {7'b0, intr_3}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
